// File: rtl/shiftreg_xfer_ctrl_if.sv
// Command/response handshake bundle between a host client and shiftreg_xfer_ctrl.
// The host drives commands and accepts responses; the controller is the slave.
interface shiftreg_xfer_ctrl_if #(
    parameter int N = 8
);
    logic         cmd_valid;
    logic         cmd_ready;
    logic [N-1:0] cmd_data;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [N-1:0] rsp_data;

    modport master (
        output cmd_valid,
        output cmd_data,
        output rsp_ready,
        input  cmd_ready,
        input  rsp_valid,
        input  rsp_data
    );

    modport slave (
        input  cmd_valid,
        input  cmd_data,
        input  rsp_ready,
        output cmd_ready,
        output rsp_valid,
        output rsp_data
    );
endinterface

// File: rtl/shiftreg_xfer_ctrl.sv
// Sequences one free-running shiftreg: load a word, shift it out MSB-first for N
// cycles while capturing ser_in, then return the captured word over a handshake.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | waiting for a command; shiftreg parked at zero
//   LOAD     | parallel-load tx_word into shiftreg
//   SHIFT    | N shift cycles, frame high, ser_out/ser_in streaming
//   CAPT     | shiftreg holds received word; copy it into rsp_data
//   RESP     | rsp_valid held until the consumer takes it
//   GAP_WAIT | GAP idle cycles before the next command may be accepted
module shiftreg_xfer_ctrl #(
    parameter int N   = 8,
    parameter int GAP = 2
) (
    input  logic                clk,
    input  logic                reset,
    shiftreg_xfer_ctrl_if.slave bus,
    input  logic                ser_in,
    output logic                ser_out,
    output logic                frame,
    output logic                busy,
    output logic                sr_load,
    output logic [N-1:0]        sr_d,
    output logic                sr_sin,
    input  logic [N-1:0]        sr_q,
    input  logic                sr_sout
);

    localparam int CW = $clog2(N + 1);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        SHIFT    = 3'd2,
        CAPT     = 3'd3,
        RESP     = 3'd4,
        GAP_WAIT = 3'd5
    } state_t;

    state_t          state;
    logic [CW-1:0]   bit_cnt;
    logic [GW-1:0]   gap_cnt;
    logic [N-1:0]    tx_word;
    logic [N-1:0]    rsp_word;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            gap_cnt  <= '0;
            tx_word  <= '0;
            rsp_word <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        tx_word <= bus.cmd_data;
                        state   <= LOAD;
                    end
                end
                LOAD: begin
                    bit_cnt <= '0;
                    state   <= SHIFT;
                end
                SHIFT: begin
                    bit_cnt <= bit_cnt + CW'(1);
                    if (bit_cnt == CW'(N - 1))
                        state <= CAPT;
                end
                CAPT: begin
                    rsp_word <= sr_q;
                    state    <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        if (GAP == 0) begin
                            state <= IDLE;
                        end else begin
                            // down-counter: terminal count at zero ends the gap
                            gap_cnt <= GW'(GAP - 1);
                            state   <= GAP_WAIT;
                        end
                    end
                end
                GAP_WAIT: begin
                    if (gap_cnt == '0)
                        state <= IDLE;
                    else
                        gap_cnt <= gap_cnt - GW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode straight from state so reset clears them without a clock.
    assign bus.cmd_ready = (state == IDLE);
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_data  = rsp_word;
    assign busy          = (state != IDLE);
    assign frame         = (state == SHIFT);
    assign ser_out       = (state == SHIFT) ? sr_sout : 1'b0;

    // shiftreg moves every clock, so outside LOAD/SHIFT it is held loaded with zero.
    assign sr_load = (state != SHIFT);
    assign sr_d    = (state == LOAD) ? tx_word : '0;
    assign sr_sin  = (state == SHIFT) ? ser_in : 1'b0;

endmodule

// File: tb/tb_shiftreg_xfer_ctrl.sv
// Directed bench for shiftreg_xfer_ctrl (N=8, GAP=2) with a behavioural shiftreg
// attached; serial input is either looped back from ser_out or driven from a table.
module tb_shiftreg_xfer_ctrl;
    localparam int N   = 8;
    localparam int GAP = 2;

    logic         clk;
    logic         reset;
    logic         loopback;
    logic         ser_in_drv;
    logic         ser_in_w;
    logic         ser_out;
    logic         frame;
    logic         busy;
    logic         sr_load;
    logic [N-1:0] sr_d;
    logic         sr_sin;
    logic [N-1:0] sr_q;
    logic         sr_sout;

    int n_checks = 0;
    int n_pass   = 0;

    shiftreg_xfer_ctrl_if #(.N(N)) bus ();

    shiftreg_xfer_ctrl #(.N(N), .GAP(GAP)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .ser_in  (ser_in_w),
        .ser_out (ser_out),
        .frame   (frame),
        .busy    (busy),
        .sr_load (sr_load),
        .sr_d    (sr_d),
        .sr_sin  (sr_sin),
        .sr_q    (sr_q),
        .sr_sout (sr_sout)
    );

    // Free-running shiftreg: load or shift left every clock, no enable.
    always @(posedge clk) sr_q <= sr_load ? sr_d : {sr_q[N-2:0], sr_sin};
    assign sr_sout  = sr_q[N-1];
    assign ser_in_w = loopback ? ser_out : ser_in_drv;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a command and return one cycle after the accepting edge (LOAD state).
    task automatic accept_cmd(input logic [7:0] d, output bit ok);
        ok = 1'b0;
        bus.cmd_data  = d;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (bus.cmd_ready) begin
                ok = 1'b1;
                tick();
                break;
            end
            tick();
        end
        bus.cmd_valid = 1'b0;
    endtask

    // Runs one transfer up to the first RESP cycle; pat[7] is the first ser_in bit.
    task automatic run_frame(input logic [7:0] tx, input logic [7:0] pat, input bit lb,
                             output logic [7:0] seq, output int fcnt, output int lat,
                             output bit ok);
        bit a;
        ok = 1'b1;
        loopback = lb;
        ser_in_drv = 1'b0;
        seq = '0;
        fcnt = 0;
        accept_cmd(tx, a);
        if (!a) ok = 1'b0;
        fcnt += int'(frame);
        tick();
        for (int k = 0; k < N; k++) begin
            ser_in_drv = pat[N-1-k];
            seq[N-1-k] = ser_out;
            fcnt += int'(frame);
            tick();
        end
        fcnt += int'(frame);
        lat = N + 1;
        while (!bus.rsp_valid && lat < 40) begin
            tick();
            lat++;
        end
        ser_in_drv = 1'b0;
    endtask

    task automatic finish_rsp(output bit ok);
        ok = 1'b0;
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.cmd_ready) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        logic [7:0] seq;
        int fcnt, lat;
        bit ok;
        reset = 1'b1;
        tick();
        tick();
        n_checks++; if (bus.cmd_ready !== 1'b1) $display("FAIL rst_cmd_ready: got %b want 1", bus.cmd_ready); else n_pass++;
        n_checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid: got %b want 0", bus.rsp_valid); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if ({frame, ser_out, sr_sin} !== 3'b000) $display("FAIL rst_frame_ser: got %b want 000", {frame, ser_out, sr_sin}); else n_pass++;
        n_checks++; if (sr_load !== 1'b1) $display("FAIL rst_sr_load: got %b want 1", sr_load); else n_pass++;
        n_checks++; if (sr_d !== 8'h00) $display("FAIL rst_sr_d: got %h want 00", sr_d); else n_pass++;
        n_checks++; if (bus.rsp_data !== 8'h00) $display("FAIL rst_rsp_data: got %h want 00", bus.rsp_data); else n_pass++;
        reset = 1'b0;
        tick();
        n_checks++; if (bus.cmd_ready !== 1'b1) $display("FAIL rst_release_ready: got %b want 1", bus.cmd_ready); else n_pass++;
        tick();
        reset = 1'b1;
        #1;
        n_checks++; if ({bus.cmd_ready, busy, sr_load} !== 3'b101) $display("FAIL rst_idle_mid: got %b want 101", {bus.cmd_ready, busy, sr_load}); else n_pass++;
        tick();
        reset = 1'b0;
        tick();
        // mid-RESP: outputs must fall back without waiting for a clock
        run_frame(8'h5A, 8'h00, 1'b1, seq, fcnt, lat, ok);
        n_checks++; if (bus.rsp_valid !== 1'b1) $display("FAIL rst_pre_resp_valid: got %b want 1", bus.rsp_valid); else n_pass++;
        reset = 1'b1;
        #1;
        n_checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL rst_resp_valid: got %b want 0", bus.rsp_valid); else n_pass++;
        n_checks++; if (bus.rsp_data !== 8'h00) $display("FAIL rst_resp_data: got %h want 00", bus.rsp_data); else n_pass++;
        n_checks++; if ({bus.cmd_ready, busy, sr_load, sr_d} !== {3'b101, 8'h00}) $display("FAIL rst_resp_outs: got %b want 10100000000", {bus.cmd_ready, busy, sr_load, sr_d}); else n_pass++;
        tick();
        reset = 1'b0;
        tick();
        n_checks++; if ({bus.cmd_ready, busy} !== 2'b10) $display("FAIL rst_resp_release: got %b want 10", {bus.cmd_ready, busy}); else n_pass++;
    endtask

    task automatic test_loopback();
        logic [7:0] seq;
        int fcnt, lat;
        bit ok;
        run_frame(8'hA5, 8'h00, 1'b1, seq, fcnt, lat, ok);
        n_checks++; if (ok !== 1'b1) $display("FAIL lb_accept: got %b want 1", ok); else n_pass++;
        n_checks++; if (seq !== 8'hA5) $display("FAIL lb_ser_out: got %h want a5", seq); else n_pass++;
        n_checks++; if (fcnt !== 8) $display("FAIL lb_frame_cycles: got %0d want 8", fcnt); else n_pass++;
        n_checks++; if (lat !== 10) $display("FAIL lb_latency: got %0d want 10", lat); else n_pass++;
        n_checks++; if (bus.rsp_data !== 8'hA5) $display("FAIL lb_rsp_data: got %h want a5", bus.rsp_data); else n_pass++;
        finish_rsp(ok);
        n_checks++; if (ok !== 1'b1) $display("FAIL lb_return_idle: got %b want 1", ok); else n_pass++;
    endtask

    task automatic test_independent();
        logic [7:0] seq;
        int fcnt, lat;
        bit ok;
        run_frame(8'h3C, 8'b1100_1001, 1'b0, seq, fcnt, lat, ok);
        n_checks++; if (seq !== 8'h3C) $display("FAIL ind_ser_out: got %h want 3c", seq); else n_pass++;
        n_checks++; if (fcnt !== 8) $display("FAIL ind_frame_cycles: got %0d want 8", fcnt); else n_pass++;
        n_checks++; if (lat !== 10) $display("FAIL ind_latency: got %0d want 10", lat); else n_pass++;
        n_checks++; if (bus.rsp_data !== 8'hC9) $display("FAIL ind_rsp_data: got %h want c9", bus.rsp_data); else n_pass++;
        finish_rsp(ok);
        n_checks++; if (ok !== 1'b1) $display("FAIL ind_return_idle: got %b want 1", ok); else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [7:0] seq;
        int fcnt, lat, bad;
        bit ok;
        run_frame(8'h96, 8'h00, 1'b1, seq, fcnt, lat, ok);
        bus.cmd_data  = 8'hFF;
        bus.cmd_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 8'h96 || bus.cmd_ready !== 1'b0) bad++;
            tick();
        end
        n_checks++; if (bad !== 0) $display("FAIL bp_hold_stable: got %0d bad cycles want 0", bad); else n_pass++;
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        n_checks++; if ({bus.rsp_valid, bus.cmd_ready} !== 2'b00) $display("FAIL bp_gap1: got %b want 00", {bus.rsp_valid, bus.cmd_ready}); else n_pass++;
        tick();
        n_checks++; if (bus.cmd_ready !== 1'b0) $display("FAIL bp_gap2: got %b want 0", bus.cmd_ready); else n_pass++;
        tick();
        n_checks++; if (bus.cmd_ready !== 1'b1) $display("FAIL bp_ready_after_gap: got %b want 1", bus.cmd_ready); else n_pass++;
        bus.cmd_valid = 1'b0;
        tick();
        n_checks++; if (busy !== 1'b0) $display("FAIL bp_ff_ignored: got busy %b want 0", busy); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] cmds [3];
        logic [7:0] rsps [3];
        int acc_edge [3];
        int rise_edge [3];
        int na, nr, nrise, c;
        logic prev_ready, acc;
        cmds[0] = 8'h01; cmds[1] = 8'h80; cmds[2] = 8'hFF;
        na = 0; nr = 0; nrise = 0; c = 0;
        loopback = 1'b1;
        bus.rsp_ready = 1'b1;
        bus.cmd_data  = cmds[0];
        bus.cmd_valid = 1'b1;
        prev_ready = bus.cmd_ready;
        while ((nr < 3 || nrise < 3) && c < 100) begin
            if (bus.cmd_ready && !prev_ready && nrise < 3) begin
                rise_edge[nrise] = c;
                nrise++;
            end
            prev_ready = bus.cmd_ready;
            if (bus.rsp_valid && bus.rsp_ready && nr < 3) begin
                rsps[nr] = bus.rsp_data;
                nr++;
            end
            acc = bus.cmd_valid && bus.cmd_ready;
            tick();
            c++;
            if (acc) begin
                acc_edge[na] = c;
                na++;
                if (na < 3) bus.cmd_data = cmds[na];
                else bus.cmd_valid = 1'b0;
            end
        end
        bus.rsp_ready = 1'b0;
        n_checks++; if (na !== 3 || nr !== 3 || nrise !== 3) $display("FAIL b2b_counts: got acc %0d rsp %0d rise %0d want 3 3 3", na, nr, nrise); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            if (i < nr) begin
                n_checks++; if (rsps[i] !== cmds[i]) $display("FAIL b2b_rsp%0d: got %h want %h", i, rsps[i], cmds[i]); else n_pass++;
            end
            // ready comes back N+3+GAP cycles after each accepting edge
            if (i < nrise && i < na) begin
                n_checks++; if (rise_edge[i] - acc_edge[i] !== N + 3 + GAP) $display("FAIL b2b_spacing%0d: got %0d want %0d", i, rise_edge[i] - acc_edge[i], N + 3 + GAP); else n_pass++;
            end
        end
    endtask

    task automatic test_abort();
        logic [7:0] seq;
        int fcnt, lat, seen;
        bit ok;
        loopback = 1'b1;
        accept_cmd(8'hA5, ok);
        for (int i = 0; i < 5; i++) tick();
        n_checks++; if (frame !== 1'b1) $display("FAIL abort_in_shift: got frame %b want 1", frame); else n_pass++;
        reset = 1'b1;
        #1;
        n_checks++; if ({frame, ser_out} !== 2'b00) $display("FAIL abort_frame_ser: got %b want 00", {frame, ser_out}); else n_pass++;
        n_checks++; if ({sr_load, sr_d} !== {1'b1, 8'h00}) $display("FAIL abort_park: got %b want 100000000", {sr_load, sr_d}); else n_pass++;
        tick();
        tick();
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (bus.rsp_valid !== 1'b0) seen++;
        end
        n_checks++; if (seen !== 0) $display("FAIL abort_no_rsp: got %0d rsp_valid cycles want 0", seen); else n_pass++;
        run_frame(8'h3C, 8'h00, 1'b1, seq, fcnt, lat, ok);
        n_checks++; if (lat !== 10) $display("FAIL abort_next_latency: got %0d want 10", lat); else n_pass++;
        n_checks++; if (bus.rsp_data !== 8'h3C) $display("FAIL abort_next_rsp: got %h want 3c", bus.rsp_data); else n_pass++;
        finish_rsp(ok);
        n_checks++; if (ok !== 1'b1) $display("FAIL abort_next_idle: got %b want 1", ok); else n_pass++;
    endtask

    initial begin
        reset         = 1'b1;
        loopback      = 1'b1;
        ser_in_drv    = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = '0;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_loopback();
        test_independent();
        test_backpressure();
        test_back_to_back();
        test_abort();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
